// File: rtl/bcd_pkg.sv
// Shared definitions for the digit-serial BCD adder/subtractor.
//   BCD_MAX / BCD_ADJ : largest legal BCD digit and the +6 decimal correction
//   state_e           : controller states
//   bcd_digit_ok()    : true when a 4-bit nibble is a legal BCD digit
package bcd_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_ADJ = 4'd6;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_e;

  function automatic logic bcd_digit_ok(input logic [3:0] d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_serial_adder_if.sv
// Request/result bundle of the BCD serial adder.
//   master : drives start, sub, cin, a, b; observes busy, done, sum, cout, err
//   slave  : the adder side of the same signals
interface bcd_serial_adder_if #(parameter int DIGITS = 4);

  logic                  start;
  logic                  sub;
  logic                  cin;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   sum;
  logic                  cout;
  logic                  err;

  modport master (output start, sub, cin, a, b,
                  input  busy, done, sum, cout, err);
  modport slave  (input  start, sub, cin, a, b,
                  output busy, done, sum, cout, err);

endinterface

// File: rtl/bcd_serial_adder_digit_adder.sv
// One-digit BCD adder (combinational).
//   a, b : BCD digits (0..9)   ci : carry in
//   s    : BCD sum digit       co : decimal carry out
module bcd_digit_adder
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] raw;

  assign raw = {1'b0, a} + {1'b0, b} + {4'b0, ci};
  assign co  = raw > {1'b0, BCD_MAX};
  // Adding 6 modulo 16 skips the six unused codes 10..15.
  assign s   = co ? (raw[3:0] + BCD_ADJ) : raw[3:0];

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial multi-digit BCD adder/subtractor.
//   clk, reset : clock, synchronous active-high reset
//   bus        : start/sub/cin/a/b request in; busy/done/sum/cout/err out
// Operands are latched on an accepted start and walked one digit per clock,
// least significant first, through a single digit adder. Subtraction adds
// the nine's complement of b with an initial carry of 1 (ten's complement).
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  bcd_serial_adder_if.slave    bus
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = $clog2(DIGITS + 1);
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic            sub_q, sub_d, carry_q, carry_d;
  logic            cout_q, cout_d, err_q, err_d, done_q, done_d;

  logic [3:0]      dig_a, dig_b, dig_bp, dig_s;
  logic            dig_co;
  logic            ops_ok;

  assign dig_a  = a_q[int'(idx_q)*4 +: 4];
  assign dig_b  = b_q[int'(idx_q)*4 +: 4];
  assign dig_bp = sub_q ? (BCD_MAX - dig_b) : dig_b;

  bcd_digit_adder u_dig (
    .a  (dig_a),
    .b  (dig_bp),
    .ci (carry_q),
    .s  (dig_s),
    .co (dig_co)
  );

  // Operand check is done on the live bus so the error is known at accept.
  always_comb begin
    ops_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (!bcd_digit_ok(bus.a[4*i +: 4]) || !bcd_digit_ok(bus.b[4*i +: 4]))
        ops_ok = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d    = bus.a;
          b_d    = bus.b;
          sub_d  = bus.sub;
          sum_d  = '0;
          cout_d = 1'b0;
          err_d  = 1'b0;
          if (!ops_ok) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else begin
            state_d = RUN;
            idx_d   = '0;
            carry_d = bus.sub ? 1'b1 : bus.cin;
          end
        end
      end
      RUN: begin
        sum_d[int'(idx_q)*4 +: 4] = dig_s;
        carry_d = dig_co;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST) begin
          state_d = IDLE;
          idx_d   = '0;
          cout_d  = dig_co;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q == RUN);
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.err  = err_q;

endmodule
